// File: rtl/scurve_stream_parser_if.sv
// S-curve stream parser bus bundle.
// Word input plus record, frame and error reporting.
interface scurve_stream_parser_if;
  logic [15:0] DataIn;
  logic        DataInEnable;
  logic        RecordValid;
  logic [1:0]  RecordMode;
  logic [5:0]  RecordChannel;
  logic [9:0]  RecordDac;
  logic [31:0] RecordData;
  logic        FrameDone;
  logic [15:0] FrameRecordCount;
  logic        ErrorPulse;
  logic [2:0]  ErrorCode;
  logic [7:0]  ErrorCount;
  logic        Busy;

  modport master (
    output DataIn,
    output DataInEnable,
    input  RecordValid,
    input  RecordMode,
    input  RecordChannel,
    input  RecordDac,
    input  RecordData,
    input  FrameDone,
    input  FrameRecordCount,
    input  ErrorPulse,
    input  ErrorCode,
    input  ErrorCount,
    input  Busy
  );

  modport slave (
    input  DataIn,
    input  DataInEnable,
    output RecordValid,
    output RecordMode,
    output RecordChannel,
    output RecordDac,
    output RecordData,
    output FrameDone,
    output FrameRecordCount,
    output ErrorPulse,
    output ErrorCode,
    output ErrorCount,
    output Busy
  );
endinterface

// File: rtl/scurve_stream_parser.sv
// S-curve USB stream parser.
// Decodes framed channel/DAC/payload words into records.
module scurve_stream_parser #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input logic             Clk,
  input logic             reset,
  scurve_stream_parser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CHN,
    WAIT_DAC,
    PAY_HI,
    PAY_LO,
    WAIT_NEXT
  } state_t;

  localparam logic [15:0] W_HDR  = 16'h5343;
  localparam logic [15:0] W_TAIL = 16'hFF45;
  localparam logic [15:0] W_UNM  = 16'h43FF;

  state_t      state;
  logic [1:0]  mode;
  logic [5:0]  chn;
  logic [9:0]  dac;
  logic [15:0] pay_hi;
  logic [5:0]  exp_chn;
  logic [15:0] rec_cnt;
  logic [15:0] tmo_cnt;

  logic [15:0] d;
  logic        en;
  logic        is_hdr;
  logic        is_tail;
  logic        is_unm;
  logic        is_sch;
  logic        is_ach;
  logic        is_dac;
  logic        is_chw;
  logic [1:0]  w_mode;
  logic [5:0]  w_chn;
  logic        ach_bad;
  logic        tmo_hit;
  logic        err;
  logic [2:0]  err_code;

  assign d  = bus.DataIn;
  assign en = bus.DataInEnable;

  assign is_hdr  = d == W_HDR;
  assign is_tail = d == W_TAIL;
  assign is_unm  = d == W_UNM;
  assign is_sch  = d[15:8] == 8'h43 && d[7:6] == 2'b00;
  assign is_ach  = d[15:8] == 8'h63 && d[7:6] == 2'b00;
  assign is_dac  = d[15:12] == 4'hD && d[11:10] == 2'b00;
  assign is_chw  = is_sch | is_ach | is_unm;
  assign ach_bad = is_ach && d[5:0] != exp_chn;

  assign tmo_hit = state != IDLE &&
                   !en &&
                   tmo_cnt == TIMEOUT_CYCLES;

  assign bus.Busy = state != IDLE;

  // Mode and channel carried by a channel-class word.
  always_comb begin
    w_mode = 2'b00;
    w_chn  = d[5:0];
    unique case (1'b1)
      is_sch: w_mode = 2'b01;
      is_ach: w_mode = 2'b10;
      is_unm: begin
        w_mode = 2'b11;
        w_chn  = 6'd63;
      end
      default: w_mode = 2'b00;
    endcase
  end

  // Protocol error detection for the current cycle.
  always_comb begin
    err      = 1'b0;
    err_code = 3'd0;
    if (en) begin
      case (state)
        WAIT_CHN: begin
          if (is_hdr) begin
            err = 1'b1; err_code = 3'd4;
          end else if (!is_chw) begin
            err = 1'b1; err_code = 3'd1;
          end else if (ach_bad) begin
            err = 1'b1; err_code = 3'd2;
          end
        end
        WAIT_DAC: begin
          if (is_hdr) begin
            err = 1'b1; err_code = 3'd4;
          end else if (!is_dac) begin
            err = 1'b1; err_code = 3'd1;
          end
        end
        WAIT_NEXT: begin
          if (is_hdr) begin
            err = 1'b1; err_code = 3'd4;
          end else if (is_chw && w_mode != mode) begin
            err = 1'b1; err_code = 3'd1;
          end else if (ach_bad) begin
            err = 1'b1; err_code = 3'd2;
          end else if (!(is_chw | is_dac | is_tail)) begin
            err = 1'b1; err_code = 3'd1;
          end
        end
        default: begin
          err      = 1'b0;
          err_code = 3'd0;
        end
      endcase
    end else if (tmo_hit) begin
      err      = 1'b1;
      err_code = 3'd3;
    end
  end

  // Inter-word idle counter while a frame is open.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 16'd0;
    end else if (en || state == IDLE || tmo_hit) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Error pulse, sticky code and saturating count.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      bus.ErrorPulse <= 1'b0;
      bus.ErrorCode  <= 3'd0;
      bus.ErrorCount <= 8'd0;
    end else begin
      bus.ErrorPulse <= err;
      if (err) begin
        bus.ErrorCode <= err_code;
        if (bus.ErrorCount != 8'hFF) begin
          bus.ErrorCount <= bus.ErrorCount + 8'd1;
        end
      end
    end
  end

  // Frame FSM with registered record and frame outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      mode                 <= 2'b00;
      chn                  <= 6'd0;
      dac                  <= 10'd0;
      pay_hi               <= 16'd0;
      exp_chn              <= 6'd0;
      rec_cnt              <= 16'd0;
      bus.RecordValid      <= 1'b0;
      bus.RecordMode       <= 2'b00;
      bus.RecordChannel    <= 6'd0;
      bus.RecordDac        <= 10'd0;
      bus.RecordData       <= 32'd0;
      bus.FrameDone        <= 1'b0;
      bus.FrameRecordCount <= 16'd0;
    end else begin
      bus.RecordValid <= 1'b0;
      bus.FrameDone   <= 1'b0;
      if (en) begin
        if (is_hdr && state != PAY_HI &&
            state != PAY_LO) begin
          state   <= WAIT_CHN;
          rec_cnt <= 16'd0;
          exp_chn <= 6'd0;
        end else if (err) begin
          state <= IDLE;
        end else begin
          case (state)
            WAIT_CHN: begin
              mode  <= w_mode;
              chn   <= w_chn;
              state <= WAIT_DAC;
              if (is_ach) exp_chn <= exp_chn + 6'd1;
            end
            WAIT_DAC: begin
              dac   <= d[9:0];
              state <= PAY_HI;
            end
            PAY_HI: begin
              pay_hi <= d;
              state  <= PAY_LO;
            end
            PAY_LO: begin
              bus.RecordValid   <= 1'b1;
              bus.RecordMode    <= mode;
              bus.RecordChannel <= chn;
              bus.RecordDac     <= dac;
              bus.RecordData    <= {pay_hi, d};
              if (rec_cnt != 16'hFFFF) begin
                rec_cnt <= rec_cnt + 16'd1;
              end
              state <= WAIT_NEXT;
            end
            WAIT_NEXT: begin
              unique case (1'b1)
                is_dac: begin
                  dac   <= d[9:0];
                  state <= PAY_HI;
                end
                is_tail: begin
                  bus.FrameDone        <= 1'b1;
                  bus.FrameRecordCount <= rec_cnt;
                  state                <= IDLE;
                end
                is_chw: begin
                  chn   <= w_chn;
                  state <= WAIT_DAC;
                  if (is_ach) exp_chn <= exp_chn + 6'd1;
                end
                default: state <= IDLE;
              endcase
            end
            default: state <= IDLE;
          endcase
        end
      end else if (tmo_hit) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_scurve_stream_parser.sv
// Directed testbench for scurve_stream_parser.
// Scenario tasks with inline hand-computed checks.
module tb_scurve_stream_parser;

  logic Clk;
  logic reset;
  int   checks;
  int   errors;
  int   rv_cnt;
  int   fd_cnt;
  int   ep_cnt;

  scurve_stream_parser_if bus ();

  scurve_stream_parser #(
    .TIMEOUT_CYCLES(16'd16)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bus.RecordValid) rv_cnt <= rv_cnt + 1;
    if (bus.FrameDone)   fd_cnt <= fd_cnt + 1;
    if (bus.ErrorPulse)  ep_cnt <= ep_cnt + 1;
  end

  task automatic word(input logic [15:0] w);
    bus.DataIn       = w;
    bus.DataInEnable = 1'b1;
    @(negedge Clk);
    bus.DataInEnable = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.DataInEnable = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    bus.DataInEnable = 1'b0;
    bus.DataIn       = 16'h0000;
    reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.DataInEnable = 1'b0;
    bus.DataIn = 16'h0;
    #1;
    checks++;
    if ({bus.RecordValid, bus.FrameDone, bus.ErrorPulse,
         bus.Busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 0000",
        {bus.RecordValid, bus.FrameDone,
         bus.ErrorPulse, bus.Busy});
    end
    checks++;
    if ({bus.RecordData, bus.RecordDac, bus.RecordChannel,
         bus.RecordMode} !== 50'd0) begin
      errors++;
      $display("FAIL reset_record got %h exp 0",
        {bus.RecordData, bus.RecordDac,
         bus.RecordChannel, bus.RecordMode});
    end
    checks++;
    if ({bus.FrameRecordCount, bus.ErrorCode,
         bus.ErrorCount} !== 27'd0) begin
      errors++;
      $display("FAIL reset_counts got %h exp 0",
        {bus.FrameRecordCount, bus.ErrorCode,
         bus.ErrorCount});
    end
    do_reset();
  endtask

  task automatic test_idle_discard();
    do_reset();
    word(16'h4305);
    word(16'h1234);
    word(16'hFF45);
    checks++;
    if (bus.ErrorCount !== 8'd0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_discard got ec=%0d busy=%b exp 0 0",
        bus.ErrorCount, bus.Busy);
    end
  endtask

  task automatic test_single();
    int rv0;
    do_reset();
    rv0 = rv_cnt;
    word(16'h5343);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b exp 1", bus.Busy);
    end
    word(16'h4305);
    word(16'hD064);
    word(16'h0001);
    word(16'h2345);
    checks++;
    if (bus.RecordValid !== 1'b1 ||
        bus.RecordMode !== 2'b01 ||
        bus.RecordChannel !== 6'd5 ||
        bus.RecordDac !== 10'd100 ||
        bus.RecordData !== 32'h00012345) begin
      errors++;
      $display("FAIL single_rec got v=%b m=%b c=%0d d=%0d %h exp 1 01 5 100 00012345",
        bus.RecordValid, bus.RecordMode, bus.RecordChannel,
        bus.RecordDac, bus.RecordData);
    end
    word(16'hFF45);
    checks++;
    if (bus.FrameDone !== 1'b1 ||
        bus.FrameRecordCount !== 16'd1 ||
        bus.RecordValid !== 1'b0) begin
      errors++;
      $display("FAIL single_frame got fd=%b n=%0d rv=%b exp 1 1 0",
        bus.FrameDone, bus.FrameRecordCount, bus.RecordValid);
    end
    @(negedge Clk);
    checks++;
    if (rv_cnt - rv0 !== 1 || bus.ErrorCount !== 8'd0 ||
        bus.Busy !== 1'b0 || bus.FrameDone !== 1'b0 ||
        bus.RecordData !== 32'h00012345) begin
      errors++;
      $display("FAIL single_after got recs=%0d ec=%0d busy=%b fd=%b data=%h exp 1 0 0 0 00012345",
        rv_cnt - rv0, bus.ErrorCount, bus.Busy,
        bus.FrameDone, bus.RecordData);
    end
  endtask

  task automatic test_all64();
    int rv0;
    do_reset();
    rv0 = rv_cnt;
    word(16'h5343);
    for (int ch = 0; ch < 64; ch++) begin
      word({8'h63, 2'b00, 6'(ch)});
      word(16'hD100);
      word(16'(ch));
      word(16'(ch + 256));
      word(16'hD101);
      word(16'(ch + 512));
      word(16'(ch + 768));
    end
    checks++;
    if (bus.RecordChannel !== 6'd63 ||
        bus.RecordDac !== 10'h101 ||
        bus.RecordMode !== 2'b10 ||
        bus.RecordData !== 32'h023F033F) begin
      errors++;
      $display("FAIL all64_last got c=%0d d=%h m=%b %h exp 63 101 10 023F033F",
        bus.RecordChannel, bus.RecordDac, bus.RecordMode,
        bus.RecordData);
    end
    word(16'hFF45);
    checks++;
    if (bus.FrameDone !== 1'b1 ||
        bus.FrameRecordCount !== 16'd128) begin
      errors++;
      $display("FAIL all64_frame got fd=%b n=%0d exp 1 128",
        bus.FrameDone, bus.FrameRecordCount);
    end
    @(negedge Clk);
    checks++;
    if (rv_cnt - rv0 !== 128 || bus.ErrorCount !== 8'd0) begin
      errors++;
      $display("FAIL all64_count got recs=%0d ec=%0d exp 128 0",
        rv_cnt - rv0, bus.ErrorCount);
    end
  endtask

  task automatic test_chn_skip();
    do_reset();
    word(16'h5343);
    word(16'h6300);
    word(16'hD010);
    word(16'h1111);
    word(16'h2222);
    word(16'h6302);
    checks++;
    if (bus.ErrorPulse !== 1'b1 || bus.ErrorCode !== 3'd2 ||
        bus.ErrorCount !== 8'd1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL chn_skip got p=%b code=%0d ec=%0d busy=%b exp 1 2 1 0",
        bus.ErrorPulse, bus.ErrorCode, bus.ErrorCount, bus.Busy);
    end
    @(negedge Clk);
    checks++;
    if (bus.ErrorPulse !== 1'b0 || bus.ErrorCode !== 3'd2) begin
      errors++;
      $display("FAIL chn_skip_hold got p=%b code=%0d exp 0 2",
        bus.ErrorPulse, bus.ErrorCode);
    end
  endtask

  task automatic test_alias();
    int fd0;
    do_reset();
    fd0 = fd_cnt;
    word(16'h5343);
    word(16'h43FF);
    word(16'hD005);
    word(16'h5343);
    word(16'hFF45);
    checks++;
    if (bus.RecordValid !== 1'b1 ||
        bus.RecordData !== 32'h5343FF45 ||
        bus.RecordChannel !== 6'd63 ||
        bus.RecordMode !== 2'b11 ||
        bus.RecordDac !== 10'd5) begin
      errors++;
      $display("FAIL alias_rec got v=%b %h c=%0d m=%b d=%0d exp 1 5343FF45 63 11 5",
        bus.RecordValid, bus.RecordData, bus.RecordChannel,
        bus.RecordMode, bus.RecordDac);
    end
    word(16'hFF45);
    checks++;
    if (bus.FrameDone !== 1'b1 || fd_cnt !== fd0 ||
        bus.FrameRecordCount !== 16'd1 ||
        bus.ErrorCount !== 8'd0) begin
      errors++;
      $display("FAIL alias_frame got fd=%b early=%0d n=%0d ec=%0d exp 1 0 1 0",
        bus.FrameDone, fd_cnt - fd0,
        bus.FrameRecordCount, bus.ErrorCount);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    word(16'h5343);
    word(16'h4301);
    word(16'hD010);
    gap(16);
    checks++;
    if (bus.ErrorPulse !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got p=%b busy=%b exp 0 1",
        bus.ErrorPulse, bus.Busy);
    end
    gap(1);
    checks++;
    if (bus.ErrorPulse !== 1'b1 || bus.ErrorCode !== 3'd3 ||
        bus.ErrorCount !== 8'd1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire got p=%b code=%0d ec=%0d busy=%b exp 1 3 1 0",
        bus.ErrorPulse, bus.ErrorCode, bus.ErrorCount, bus.Busy);
    end
    word(16'h5343);
    word(16'h4301);
    word(16'hD010);
    gap(16);
    word(16'h1111);
    checks++;
    if (bus.ErrorPulse !== 1'b0 || bus.Busy !== 1'b1 ||
        bus.ErrorCount !== 8'd1) begin
      errors++;
      $display("FAIL tmo_word_wins got p=%b busy=%b ec=%0d exp 0 1 1",
        bus.ErrorPulse, bus.Busy, bus.ErrorCount);
    end
    word(16'h2222);
    checks++;
    if (bus.RecordValid !== 1'b1 ||
        bus.RecordData !== 32'h11112222) begin
      errors++;
      $display("FAIL tmo_rec got v=%b %h exp 1 11112222",
        bus.RecordValid, bus.RecordData);
    end
    word(16'hFF45);
  endtask

  task automatic test_mode_change();
    do_reset();
    word(16'h5343);
    word(16'h4301);
    word(16'hD001);
    word(16'h0000);
    word(16'h0000);
    word(16'h6300);
    checks++;
    if (bus.ErrorPulse !== 1'b1 || bus.ErrorCode !== 3'd1 ||
        bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_change got p=%b code=%0d busy=%b exp 1 1 0",
        bus.ErrorPulse, bus.ErrorCode, bus.Busy);
    end
  endtask

  task automatic test_hdr_restart();
    do_reset();
    word(16'h5343);
    word(16'h4301);
    word(16'h5343);
    checks++;
    if (bus.ErrorPulse !== 1'b1 || bus.ErrorCode !== 3'd4 ||
        bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL hdr_restart got p=%b code=%0d busy=%b exp 1 4 1",
        bus.ErrorPulse, bus.ErrorCode, bus.Busy);
    end
    word(16'h4302);
    word(16'hD003);
    word(16'hABCD);
    word(16'hEF01);
    word(16'hFF45);
    checks++;
    if (bus.FrameDone !== 1'b1 ||
        bus.FrameRecordCount !== 16'd1 ||
        bus.RecordChannel !== 6'd2 ||
        bus.RecordData !== 32'hABCDEF01) begin
      errors++;
      $display("FAIL hdr_restart_frame got fd=%b n=%0d c=%0d %h exp 1 1 2 ABCDEF01",
        bus.FrameDone, bus.FrameRecordCount,
        bus.RecordChannel, bus.RecordData);
    end
  endtask

  task automatic test_reset_mid();
    int rv0;
    do_reset();
    word(16'h5343);
    word(16'h4307);
    word(16'hD020);
    word(16'hAAAA);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.RecordValid !== 1'b0 ||
        bus.RecordData !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_async got busy=%b rv=%b %h exp 0 0 0",
        bus.Busy, bus.RecordValid, bus.RecordData);
    end
    bus.DataIn       = 16'hBBBB;
    bus.DataInEnable = 1'b1;
    @(negedge Clk);
    bus.DataInEnable = 1'b0;
    reset = 1'b0;
    rv0 = rv_cnt;
    gap(3);
    checks++;
    if (rv_cnt !== rv0 || bus.ErrorPulse !== 1'b0 ||
        bus.ErrorCount !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_quiet got recs=%0d ec=%0d exp 0 0",
        rv_cnt - rv0, bus.ErrorCount);
    end
    word(16'h5343);
    word(16'h4309);
    word(16'hD030);
    word(16'h0102);
    word(16'h0304);
    word(16'hFF45);
    @(negedge Clk);
    checks++;
    if (rv_cnt - rv0 !== 1 || bus.RecordChannel !== 6'd9 ||
        bus.RecordData !== 32'h01020304 ||
        bus.FrameRecordCount !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_frame got recs=%0d c=%0d %h n=%0d exp 1 9 01020304 1",
        rv_cnt - rv0, bus.RecordChannel, bus.RecordData,
        bus.FrameRecordCount);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rv_cnt = 0;
    fd_cnt = 0;
    ep_cnt = 0;
    test_reset();
    test_idle_discard();
    test_single();
    test_all64();
    test_chn_skip();
    test_alias();
    test_timeout();
    test_mode_change();
    test_hdr_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scurve_stream_parser.md
SCURVE_STREAM_PARSER -- requirements
Module: scurve_stream_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd40000: idle cycles allowed between words while a frame is open.
REQ-002 Clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 DataIn  input  16  S-curve stream word from the USB data path.
REQ-005 DataInEnable  input  1  DataIn is valid this cycle; one word per asserted cycle; back-to-back words allowed.
REQ-006 RecordValid  output  1  one-cycle pulse when a record is complete.
REQ-007 RecordMode  output  2  01 single channel (0x43xx), 10 all-64 channel (0x63xx), 11 unmask-all (0x43FF).
REQ-008 RecordChannel  output  6  channel of the current record; 6'd63 in unmask-all mode.
REQ-009 RecordDac  output  10  DAC code of the current record.
REQ-010 RecordData  output  32  {first payload word, second payload word}.
REQ-011 FrameDone  output  1  one-cycle pulse when a tail word closes a frame.
REQ-012 FrameRecordCount  output  16  number of records in the frame; valid while FrameDone is high and held afterwards.
REQ-013 ErrorPulse  output  1  one-cycle pulse on any protocol error.
REQ-014 ErrorCode  output  3  code of the last error; held until the next error.
REQ-015 ErrorCount  output  8  total error count; saturates at 8'hFF.
REQ-016 Busy  output  1  high while a frame is open (state not IDLE).

Function
REQ-017 Words are decoded only in cycles where DataInEnable=1; all other cycles leave the state unchanged, except for the timeout counter.
REQ-018 Word classes:
- HDR = 16'h5343
- TAIL = 16'hFF45
- UNM = 16'h43FF
- SCH = 8'h43, 2'b00, chn
- ACH = 8'h63, 2'b00, chn
- DAC = 4'hD, 2'b00, dac
- Any other word is OTHER.
REQ-019 States: IDLE, WAIT_CHN, WAIT_DAC, PAY_HI, PAY_LO, WAIT_NEXT.
REQ-020 IDLE: HDR goes to WAIT_CHN, clears the record counter and sets the expected ACH channel to 0. Every non-HDR word is discarded silently, with no error.
REQ-021 WAIT_CHN: SCH, ACH or UNM latches mode and channel and goes to WAIT_DAC. TAIL or OTHER raises error 1 and goes to IDLE.
REQ-022 ACH channel check: in WAIT_CHN and WAIT_NEXT, an ACH whose chn is not the expected value raises error 2 and goes to IDLE. On acceptance the expected value increments, wrapping 63 to 0.
REQ-023 WAIT_DAC: DAC latches dac[9:0] and goes to PAY_HI. Any other word raises error 1 and goes to IDLE.
REQ-024 PAY_HI: the word is taken as raw payload, including HDR or TAIL patterns, and goes to PAY_LO.
REQ-025 PAY_LO: the word is taken as raw payload and the state goes to WAIT_NEXT.
REQ-026 Record output: the cycle after the PAY_LO word, RecordValid=1 with Record* stable. The record counter increments and saturates at 16'hFFFF.
REQ-027 WAIT_NEXT:
- DAC goes to PAY_HI, keeping the current channel.
- SCH, ACH or UNM goes to WAIT_DAC. A mode change within a frame raises error 1 and goes to IDLE.
- TAIL pulses FrameDone the next cycle and goes to IDLE.
- OTHER raises error 1 and goes to IDLE.
REQ-028 HDR received in WAIT_CHN, WAIT_DAC or WAIT_NEXT raises error 4 and restarts the frame, going to WAIT_CHN exactly as from IDLE.
REQ-029 Timeout: a 16-bit counter clears on every DataInEnable cycle and in IDLE, and otherwise increments. On reaching TIMEOUT_CYCLES it raises error 3, goes to IDLE and clears.
REQ-030 If a word and the timeout limit occur in the same cycle, the word wins and no timeout is raised.
REQ-031 Error reporting: ErrorPulse, ErrorCode update and ErrorCount increment occur together, one cycle after the offending word or timeout.
REQ-032 An error never produces RecordValid or FrameDone.
REQ-033 Record* outputs hold their last values between RecordValid pulses.

Reset
REQ-034 While reset=1, asynchronously:
- state goes to IDLE;
- all outputs go to 0;
- internal counters, the expected channel and latched fields go to 0.
REQ-035 Reset asserted mid-frame discards the partial record; no pulses are generated on or after release.

Verification
REQ-036 Single-channel frame: HDR, 16'h4305, 16'hD064, 16'h0001, 16'h2345, TAIL -> RecordValid once with Mode=01, Channel=5, Dac=100, Data=32'h00012345; FrameDone with FrameRecordCount=1; no error.
REQ-037 All-64 frame, channels 0..63, DAC steps 0x100 and 0x101 each, back-to-back words -> 128 RecordValid pulses, FrameRecordCount=128, ErrorCount=0.
REQ-038 Channel skip: HDR, 16'h6300, DAC, 2 payload words, 16'h6302 -> ErrorPulse with ErrorCode=2, ErrorCount=1, Busy=0.
REQ-039 Payload alias: HDR, UNM, DAC, payload 16'h5343, 16'hFF45, TAIL -> one record with Data=32'h5343FF45, Channel=63, Mode=11, then FrameDone; no error.
REQ-040 Timeout: TIMEOUT_CYCLES=16 with a 16-cycle gap after the DAC word -> ErrorCode=3, IDLE. Repeat with a word arriving on the limit cycle -> no error.
REQ-041 Reset mid-PAY_LO then a full valid frame -> outputs 0 during reset; only the new frame's record is reported.
